// File: rtl/imm_ext_seq.sv
// RV32I immediate extractor: instruction words are buffered in a small FIFO and
// decoded one at a time into a sign-extended immediate plus its format code.
module imm_ext_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        imm_valid,
    input  logic        imm_ready,
    output logic [31:0] imm,
    output logic [2:0]  imm_type,
    output logic        illegal,
    output logic [15:0] ext_count
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  PTR_ONE = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUT    = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd7
    } fmt_e;

    state_e          state_q, state_d;
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     imm_q, imm_d;
    fmt_e            imm_type_q, imm_type_d;
    logic            illegal_q, illegal_d;
    logic [15:0]     ext_count_q, ext_count_d;
    logic [31:0]     dec_imm;
    fmt_e            dec_fmt;
    logic            full, empty, push, pop;

    // The extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push        = instr_valid && !full;
    assign instr_ready = !full;

    assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    // NOTE: the storage array is not reset; only the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= instr;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        unique case (instr_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = {{20{instr_q[31]}}, instr_q[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                           instr_q[30:25], instr_q[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = {instr_q[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                           instr_q[20], instr_q[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        imm_type_d  = imm_type_q;
        illegal_d   = illegal_q;
        ext_count_d = ext_count_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    instr_d = mem_q[rd_ptr_q[PTR_W-1:0]];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                imm_d      = dec_imm;
                imm_type_d = dec_fmt;
                illegal_d  = (dec_fmt == FMT_NONE);
                state_d    = OUT;
            end
            OUT: begin
                // The result registers stay untouched here, so a stalled output holds steady.
                if (imm_ready) begin
                    ext_count_d = ext_count_q + 16'd1;
                    if (!empty) begin
                        pop     = 1'b1;
                        instr_d = mem_q[rd_ptr_q[PTR_W-1:0]];
                        state_d = DECODE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            instr_q     <= '0;
            imm_q       <= '0;
            imm_type_q  <= FMT_NONE;
            illegal_q   <= 1'b0;
            ext_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            imm_type_q  <= imm_type_d;
            illegal_q   <= illegal_d;
            ext_count_q <= ext_count_d;
        end
    end

    assign imm_valid = (state_q == OUT);
    assign imm       = imm_q;
    assign imm_type  = imm_type_q;
    assign illegal   = illegal_q;
    assign ext_count = ext_count_q;

endmodule

// File: tb/tb_imm_ext_seq.sv
// Bench for imm_ext_seq: stimulus feeds a scoreboard of model results at acceptance,
// a forked monitor pops and compares each delivered result.
module tb_imm_ext_seq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic        imm_valid;
    logic        imm_ready = 1'b0;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic        illegal;
    logic [15:0] ext_count;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } res_t;

    int          total = 0;
    int          bad = 0;
    res_t        exp_q[$];
    logic [31:0] stim_q[$];
    logic [31:0] got_imm[$];
    logic [2:0]  got_typ[$];
    logic        got_ill[$];
    int          accepted = 0;
    int          delivered = 0;
    logic [15:0] exp_count = '0;
    bit          rand_ready = 1'b0;
    bit          rand_gap = 1'b0;
    res_t        held;
    bit          held_valid = 1'b0;

    imm_ext_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .imm_valid   (imm_valid),
        .imm_ready   (imm_ready),
        .imm         (imm),
        .imm_type    (imm_type),
        .illegal     (illegal),
        .ext_count   (ext_count)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference decoder built from the format tables with signed arithmetic.
    function automatic res_t ref_model(input logic [31:0] w);
        res_t               r;
        logic [6:0]         op;
        logic signed [11:0] f12;
        logic signed [12:0] f13;
        logic signed [20:0] f21;
        op = w[6:0];
        r.imm = 32'd0;
        r.typ = 3'd7;
        r.ill = 1'b1;
        if (op inside {7'b0010011, 7'b0000011, 7'b1100111}) begin
            f12 = w[31:20];
            r.imm = int'(f12);
            r.typ = 3'd0;
            r.ill = 1'b0;
        end else if (op == 7'b0100011) begin
            f12 = {w[31:25], w[11:7]};
            r.imm = int'(f12);
            r.typ = 3'd1;
            r.ill = 1'b0;
        end else if (op == 7'b1100011) begin
            f13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            r.imm = int'(f13);
            r.typ = 3'd2;
            r.ill = 1'b0;
        end else if (op inside {7'b0110111, 7'b0010111}) begin
            r.imm = w & 32'hFFFF_F000;
            r.typ = 3'd3;
            r.ill = 1'b0;
        end else if (op == 7'b1101111) begin
            f21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
            r.imm = int'(f21);
            r.typ = 3'd4;
            r.ill = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [6:0]  ops [9] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) == 9) w[6:0] = 7'($urandom);
        else                           w[6:0] = ops[$urandom_range(0, 8)];
        return w;
    endfunction

    task automatic monitor_loop();
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_count  = '0;
                held_valid = 1'b0;
                continue;
            end
            if (held_valid) begin
                check("hold_valid", 32'(imm_valid), 32'd1);
                check("hold_imm", imm, held.imm);
                check("hold_type", 32'(imm_type), 32'(held.typ));
                check("hold_illegal", 32'(illegal), 32'(held.ill));
            end
            held_valid = 1'b0;
            if (imm_valid) begin
                if (imm_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_imm", imm, e.imm);
                        check("result_type", 32'(imm_type), 32'(e.typ));
                        check("result_illegal", 32'(illegal), 32'(e.ill));
                        check("ext_count_before", 32'(ext_count), 32'(exp_count));
                    end
                    got_imm.push_back(imm);
                    got_typ.push_back(imm_type);
                    got_ill.push_back(illegal);
                    exp_count = exp_count + 16'd1;
                    delivered++;
                end else begin
                    held.imm   = imm;
                    held.typ   = imm_type;
                    held.ill   = illegal;
                    held_valid = 1'b1;
                end
            end
            if (instr_valid && instr_ready) exp_q.push_back(ref_model(instr));
        end
    endtask

    task automatic load(input logic [31:0] w);
        stim_q.push_back(w);
        if (!instr_valid) begin
            instr_valid = 1'b1;
            instr       = stim_q[0];
        end
    endtask

    // One clock: inputs are updated 1 time unit after the rising edge.
    task automatic step();
        logic acc;
        @(negedge clk);
        acc = instr_valid && instr_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(stim_q.pop_front());
            accepted++;
        end
        if (rand_ready) imm_ready = 1'($urandom_range(0, 1));
        if (!(instr_valid && !acc)) begin
            if (stim_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                instr_valid = 1'b1;
                instr       = stim_q[0];
            end else begin
                instr_valid = 1'b0;
                instr       = $urandom;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0 || instr_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_pending", 32'(stim_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
        check({tag, "_imm_valid"}, 32'(imm_valid), 32'd0);
        check({tag, "_imm"}, imm, 32'd0);
        check({tag, "_imm_type"}, 32'(imm_type), 32'd7);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
        check({tag, "_ext_count"}, 32'(ext_count), 32'd0);
    endtask

    logic [31:0] b2b_words [4] = '{32'hFE20AE23, 32'h00000463, 32'h123450B7, 32'h0000006F};
    logic [31:0] b2b_imm   [4] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'h00000000};
    logic [31:0] stall_words [6] = '{32'h00500093, 32'hFFC42303, 32'h00112623,
                                     32'hFE0008E3, 32'h800000B7, 32'h0000007F};

    initial begin
        int base;
        int acc0;
        int del0;

        fork
            monitor_loop();
        join_none

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single I-type word: two-edge latency to imm_valid.
        imm_ready = 1'b1;
        load(32'hFFF00093);
        step();
        check("accept_first_edge", 32'(accepted), 32'd1);
        check("latency_edge_n", 32'(imm_valid), 32'd0);
        step();
        check("latency_edge_n1", 32'(imm_valid), 32'd0);
        step();
        check("latency_edge_n2", 32'(imm_valid), 32'd1);
        step();
        check("addi_imm", got_imm[0], 32'hFFFFFFFF);
        check("addi_type", 32'(got_typ[0]), 32'd0);
        check("addi_illegal", 32'(got_ill[0]), 32'd0);
        check("addi_ext_count", 32'(ext_count), 32'd1);

        // Back-to-back S, B, U, J.
        base = got_imm.size();
        for (int i = 0; i < 4; i++) load(b2b_words[i]);
        drain(60);
        for (int i = 0; i < 4; i++) begin
            check("b2b_imm", got_imm[base + i], b2b_imm[i]);
            check("b2b_type", 32'(got_typ[base + i]), 32'(i + 1));
        end

        // Opcode without an immediate format.
        base = got_imm.size();
        load(32'h0000007F);
        drain(20);
        check("none_imm", got_imm[base], 32'd0);
        check("none_type", 32'(got_typ[base]), 32'd7);
        check("none_illegal", 32'(got_ill[base]), 32'd1);
        check("none_ext_count", 32'(ext_count), 32'd6);

        // Backpressure: one word in the output stage plus a full FIFO.
        imm_ready = 1'b0;
        acc0 = accepted;
        del0 = delivered;
        for (int i = 0; i < 6; i++) load(stall_words[i]);
        repeat (20) step();
        check("stall_accepted", 32'(accepted - acc0), 32'd5);
        check("stall_instr_ready", 32'(instr_ready), 32'd0);
        check("stall_imm_valid", 32'(imm_valid), 32'd1);
        imm_ready = 1'b1;
        drain(80);
        check("stall_all_accepted", 32'(accepted - acc0), 32'd6);
        check("stall_delivered", 32'(delivered - del0), 32'd6);

        // Reset while results are pending.
        imm_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(stall_words[i]);
        repeat (12) step();
        check("pre_reset_valid", 32'(imm_valid), 32'd1);
        check("pre_reset_ready", 32'(instr_ready), 32'd1);
        rst_n = 1'b0;
        stim_q.delete();
        instr_valid = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        imm_ready = 1'b1;
        del0 = delivered;
        repeat (10) step();
        check("post_reset_none", 32'(delivered - del0), 32'd0);
        check("post_reset_valid", 32'(imm_valid), 32'd0);
        check("post_reset_count", 32'(ext_count), 32'd0);

        // Randomized traffic with random backpressure and offer gaps.
        rand_ready = 1'b1;
        rand_gap   = 1'b1;
        del0 = delivered;
        for (int i = 0; i < 150; i++) load(gen_word());
        drain(3000);
        check("random_delivered", 32'(delivered - del0), 32'd150);
        rand_ready = 1'b0;
        rand_gap   = 1'b0;
        imm_ready  = 1'b1;

        // Counter wrap: start the count just below the top, then deliver two more.
        force dut.ext_count_q = 16'hFFFE;
        exp_count = 16'hFFFE;
        repeat (2) step();
        release dut.ext_count_q;
        step();
        check("preload_count", 32'(ext_count), 32'h0000FFFE);
        load(32'h00100093);
        load(32'h00200093);
        drain(30);
        check("wrap_count", 32'(ext_count), 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_ext_seq.md
IMM_EXT_SEQ -- requirements
Module: imm_ext_seq

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2).
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  producer offers instr.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 instr_ready  output  1  buffer can accept.
REQ-007 imm_valid  output  1  imm/imm_type/illegal valid.
REQ-008 imm_ready  input  1  consumer accepts result.
REQ-009 imm  output  32  sign-extended immediate.
REQ-010 imm_type  output  3  I=0, S=1, B=2, U=3, J=4, NONE=7.
REQ-011 illegal  output  1  opcode has no immediate format.
REQ-012 ext_count  output  16  results delivered, wraps 0xFFFF->0x0000.

Function
REQ-013 Input accepted on the rising edge where instr_valid && instr_ready; written to FIFO tail.
REQ-014 instr_ready SHALL equal !full; no same-cycle pass-through, so a push never occurs while full.
REQ-015 Producer holds instr/instr_valid until accepted; instr_valid while instr_ready=0 is ignored.
REQ-016 FSM states IDLE, DECODE, OUT; reset state IDLE.
REQ-017 IDLE: FIFO non-empty -> pop head into instr_q, go DECODE; else stay.
REQ-018 DECODE: register imm, imm_type, illegal from instr_q; go OUT (one cycle, unconditional).
REQ-019 OUT: imm_valid=1; imm_ready=0 -> stay, outputs held stable; imm_ready=1 -> ext_count+1, then pop and go DECODE if FIFO non-empty, else IDLE.
REQ-020 imm_valid SHALL be 1 only in OUT.
REQ-021 Latency: word accepted into empty FIFO while FSM in IDLE at edge N -> imm_valid high after edge N+2.
REQ-022 Sustained throughput one result per 2 cycles with imm_ready tied high.
REQ-023 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-024 Results delivered strictly in acceptance order.
REQ-025 Opcode map: 0010011, 0000011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; others -> NONE, illegal=1, imm=0.
REQ-026 I: sign-extend instr[31:20] to 32 bits.
REQ-027 S: sign-extend {instr[31:25], instr[11:7]}.
REQ-028 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-029 U: {instr[31:12], 12'b0}, no extension.
REQ-030 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-031 Sign bit for all extended formats SHALL be instr[31].
REQ-032 FIFO pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer bit or occupancy counter.

Reset
REQ-033 rst_n low, at any time, SHALL immediately force: FSM IDLE, FIFO empty, instr_ready=1, imm_valid=0, imm=0, imm_type=7, illegal=0, ext_count=0.
REQ-034 Reset mid-operation discards buffered and in-flight instructions; nothing is emitted after release until new acceptance.
REQ-035 First acceptance possible on first rising edge after rst_n deasserts.

Verification
REQ-036 instr=0xFFF00093, imm_ready=1 -> 2 cycles after accept: imm=0xFFFFFFFF, imm_type=0, illegal=0, ext_count=1.
REQ-037 Back-to-back 0xFE20AE23, 0x00000463, 0x123450B7, 0x0000006F -> imm 0xFFFFFFFC/1, 0x00000008/2, 0x12345000/3, 0x00000000/4, in order.
REQ-038 instr=0x0000007F -> imm=0, imm_type=7, illegal=1, still handshaken, ext_count increments.
REQ-039 imm_ready=0, offer 6 words, FIFO_DEPTH=4 -> 5 accepted (1 in OUT, 4 buffered), instr_ready=0, outputs stable; release -> 5 results in order, then 6th accepted.
REQ-040 Assert rst_n=0 with 3 words buffered and imm_valid=1 -> all outputs at reset values same cycle; after release no stale result appears.
REQ-041 Preload ext_count to 0xFFFF via 65535 deliveries, deliver one more -> ext_count=0x0000.
